pulse_meter_sched: RTL and testbench

- Round-robin measurement scheduler that shares one pulse-counting gate datapath between N_CH asynchronous pulse inputs.
- For each enabled channel in turn it opens a fixed gate window and counts rising edges on that channel.
- It then presents the saturated count with a valid/ready handshake to the downstream display/report logic.
- Sits between the raw board pulse pins and the segment/LED display path. It replaces the single-channel free-running counter with a sequenced, multi-channel one.

---
 rtl/pulse_meter_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_pulse_meter_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter_sched.sv
// ---------------------------------------------------------------------------
// pulse_meter_sched
//
// Round-robin pulse meter. One gate/counter datapath is time-shared between
// N_CH asynchronous pulse inputs. For each enabled channel in turn it opens a
// gate window of WIN_CYCLES clocks, counts rising edges on that channel
// (saturating at all-ones), and presents the result with a valid/ready
// handshake.
//
// Ports:
//   clk_i           system clock
//   rst_n_i         asynchronous active-low reset
//   enable_i        run the scheduler; low aborts an open window
//   ch_en_i         per-channel enable mask, sampled when a channel is picked
//   pulse_i         raw asynchronous pulse inputs
//   busy_o          high whenever the scheduler is not idle
//   cur_ch_o        channel currently selected
//   result_valid_o  result registers hold an unaccepted measurement
//   result_ready_i  downstream accepts the result
//   result_ch_o     channel the result belongs to
//   result_cnt_o    saturated rising-edge count
//   result_ovf_o    count saturated during the window
// ---------------------------------------------------------------------------
module pulse_meter_sched #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter int TIM_W      = 28,
    parameter int WIN_CYCLES = 200000000
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic [N_CH-1:0]         ch_en_i,
    input  logic [N_CH-1:0]         pulse_i,
    output logic                    busy_o,
    output logic [$clog2(N_CH)-1:0] cur_ch_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [$clog2(N_CH)-1:0] result_ch_o,
    output logic [CNT_W-1:0]        result_cnt_o,
    output logic                    result_ovf_o
);

    localparam int                CH_W     = $clog2(N_CH);
    localparam logic [TIM_W-1:0]  TIM_LAST = TIM_W'(WIN_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GATE,
        REPORT
    } state_t;

    state_t state_q, state_d;

    logic [N_CH-1:0]  sync1_q, sync1_d;
    logic [N_CH-1:0]  sync2_q, sync2_d;
    logic [N_CH-1:0]  sync3_q, sync3_d;
    logic [N_CH-1:0]  edge_w;
    logic             edge_sel;

    logic [CH_W-1:0]  start_q, start_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [TIM_W-1:0] tim_q, tim_d;

    logic             result_valid_q, result_valid_d;
    logic [CH_W-1:0]  result_ch_q, result_ch_d;
    logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
    logic             result_ovf_q, result_ovf_d;

    logic [N_CH-1:0]  rot_en;
    logic [CH_W:0]    cand;
    logic [CH_W-1:0]  sel_ch;

    // The synchronizers run in every state, so switching channels needs no
    // settling time: the history flop of the new channel is already valid.
    assign edge_w   = sync2_q & ~sync3_q;
    assign edge_sel = edge_w[cur_ch_q];

    // Round-robin pick. start_q is the first candidate (one past the last
    // channel that produced a result). The mask is rotated so bit i means
    // channel start_q+i; scanning from the top down leaves the nearest set
    // bit in sel_ch. When only the last channel is enabled the wrap brings
    // the search back to it.
    always_comb begin
        rot_en = N_CH'({ch_en_i, ch_en_i} >> start_q);
        sel_ch = start_q;
        cand   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = {1'b0, start_q} + (CH_W + 1)'(i);
            if (cand >= (CH_W + 1)'(N_CH)) begin
                cand = cand - (CH_W + 1)'(N_CH);
            end
            if (rot_en[i]) begin
                sel_ch = cand[CH_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Dropping enable_i abandons a window immediately,
    // but a finished result is always held until it has been accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i && |ch_en_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = enable_i ? GATE : IDLE;
            end
            GATE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (tim_q == TIM_LAST) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (result_ready_i) begin
                    state_d = (enable_i && |ch_en_i) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. The last gate cycle still counts its own edge, so the result
    // registers are loaded from cnt_d/ovf_d rather than the flops. The
    // round-robin pointer only advances when a result is actually produced,
    // so an aborted channel is measured again on restart.
    always_comb begin
        sync1_d        = pulse_i;
        sync2_d        = sync1_q;
        sync3_d        = sync2_q;
        start_d        = start_q;
        cur_ch_d       = cur_ch_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        tim_d          = tim_q;
        result_valid_d = result_valid_q;
        result_ch_d    = result_ch_q;
        result_cnt_d   = result_cnt_q;
        result_ovf_d   = result_ovf_q;

        case (state_q)
            LOAD: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                tim_d = '0;
            end
            GATE: begin
                tim_d = tim_q + TIM_W'(1);
                if (edge_sel) begin
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (enable_i && tim_q == TIM_LAST) begin
                    result_valid_d = 1'b1;
                    result_ch_d    = cur_ch_q;
                    result_cnt_d   = cnt_d;
                    result_ovf_d   = ovf_d;
                    start_d        = (cur_ch_q == CH_LAST) ? '0
                                                           : cur_ch_q + CH_W'(1);
                end
            end
            REPORT: begin
                if (result_ready_i) begin
                    result_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // The channel is chosen on the edge that enters LOAD, using the mask
        // present at that moment.
        if (state_d == LOAD && state_q != LOAD) begin
            cur_ch_d = sel_ch;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            sync3_q        <= '0;
            start_q        <= '0;
            cur_ch_q       <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            tim_q          <= '0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_cnt_q   <= '0;
            result_ovf_q   <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            start_q        <= start_d;
            cur_ch_q       <= cur_ch_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            tim_q          <= tim_d;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_cnt_q   <= result_cnt_d;
            result_ovf_q   <= result_ovf_d;
        end
    end

    // Outputs.
    always_comb begin
        busy_o         = (state_q != IDLE);
        cur_ch_o       = cur_ch_q;
        result_valid_o = result_valid_q;
        result_ch_o    = result_ch_q;
        result_cnt_o   = result_cnt_q;
        result_ovf_o   = result_ovf_q;
    end

endmodule

// File: tb/tb_pulse_meter_sched.sv
// ---------------------------------------------------------------------------
// tb_pulse_meter_sched
//
// Directed bench for pulse_meter_sched. The main instance uses a 16-cycle
// window with an 8-bit count; a second instance with a 3-bit count is used
// to exercise saturation. Channel k of the main instance is driven with a
// free-running square wave of period 2*(k+1) clocks.
// ---------------------------------------------------------------------------
module tb_pulse_meter_sched;

    logic       clk;
    logic       rst_n;

    logic       enable;
    logic [3:0] ch_en;
    logic [3:0] sq_wave;
    logic       ready;
    logic       busy;
    logic [1:0] cur_ch;
    logic       res_valid;
    logic [1:0] res_ch;
    logic [7:0] res_cnt;
    logic       res_ovf;

    logic       s_enable;
    logic [3:0] s_ch_en;
    logic       sat_bit;
    logic [3:0] s_pulse;
    logic       s_ready;
    logic       s_busy;
    logic [1:0] s_cur_ch;
    logic       s_valid;
    logic [1:0] s_res_ch;
    logic [2:0] s_res_cnt;
    logic       s_res_ovf;

    int checks;
    int errors;
    int ph [4];

    assign s_pulse = {3'b000, sat_bit};

    pulse_meter_sched #(
        .N_CH(4), .CNT_W(8), .TIM_W(8), .WIN_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .ch_en_i(ch_en),
        .pulse_i(sq_wave), .busy_o(busy), .cur_ch_o(cur_ch),
        .result_valid_o(res_valid), .result_ready_i(ready),
        .result_ch_o(res_ch), .result_cnt_o(res_cnt), .result_ovf_o(res_ovf)
    );

    pulse_meter_sched #(
        .N_CH(4), .CNT_W(3), .TIM_W(8), .WIN_CYCLES(16)
    ) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(s_enable), .ch_en_i(s_ch_en),
        .pulse_i(s_pulse), .busy_o(s_busy), .cur_ch_o(s_cur_ch),
        .result_valid_o(s_valid), .result_ready_i(s_ready),
        .result_ch_o(s_res_ch), .result_cnt_o(s_res_cnt), .result_ovf_o(s_res_ovf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave sources: channel k toggles every k+1 falling edges.
    initial begin
        sq_wave = '0;
        for (int k = 0; k < 4; k++) ph[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                ph[k] = ph[k] + 1;
                if (ph[k] == k + 1) begin
                    ph[k] = 0;
                    sq_wave[k] = ~sq_wave[k];
                end
            end
        end
    end

    // Reset both instances and leave the schedulers idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        enable   = 1'b0;
        s_enable = 1'b0;
        ready    = 1'b1;
        s_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait, bounded, for the main instance to raise result_valid_o.
    task automatic wait_valid(input int max_cyc, output logic ok, output int waited);
        ok     = 1'b0;
        waited = 0;
        while (waited < max_cyc && !ok) begin
            @(negedge clk);
            waited++;
            if (res_valid) ok = 1'b1;
        end
    endtask

    // Everything clears while reset is held, even with enable high.
    task automatic test_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        ch_en  = 4'b1111;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d, expected 0", busy); end
        checks++; if (cur_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_cur_ch: got %0d, expected 0", cur_ch); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0d, expected 0", res_valid); end
        checks++; if (res_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_res_ch: got %0d, expected 0", res_ch); end
        checks++; if (res_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_res_cnt: got %0d, expected 0", res_cnt); end
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_ovf: got %0d, expected 0", res_ovf); end
        checks++; if (s_busy !== 1'b0 || s_cur_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_sat: got busy %0d ch %0d, expected 0 0", s_busy, s_cur_ch); end
        enable = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_disabled: got %0d, expected 0", busy); end
    endtask

    // All channels enabled, ready high: ch 0,1,2,3,0 every 18 cycles.
    task automatic test_round_robin();
        logic ok;
        int   waited;
        int   exp_ch  [5] = '{0, 1, 2, 3, 0};
        int   exp_cnt [5] = '{8, 4, 2, 2, 8};
        do_reset();
        ch_en  = 4'b1111;
        enable = 1'b1;
        for (int r = 0; r < 5; r++) begin
            wait_valid(40, ok, waited);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL rr_timeout[%0d]: got no valid, expected valid within 40 cycles", r);
                break;
            end
            checks++; if (waited != 18) begin errors++; $display("[TB] FAIL rr_period[%0d]: got %0d, expected 18", r, waited); end
            checks++; if (int'(res_ch) != exp_ch[r]) begin errors++; $display("[TB] FAIL rr_ch[%0d]: got %0d, expected %0d", r, res_ch, exp_ch[r]); end
            checks++;
            if (exp_ch[r] == 2) begin
                if (res_cnt !== 8'd2 && res_cnt !== 8'd3) begin errors++; $display("[TB] FAIL rr_cnt[%0d]: got %0d, expected 2 or 3", r, res_cnt); end
            end else begin
                if (int'(res_cnt) != exp_cnt[r]) begin errors++; $display("[TB] FAIL rr_cnt[%0d]: got %0d, expected %0d", r, res_cnt, exp_cnt[r]); end
            end
            checks++; if (res_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rr_ovf[%0d]: got %0d, expected 0", r, res_ovf); end
        end
        enable = 1'b0;
    endtask

    // 3-bit counter sees 8 edges then a silent window.
    task automatic test_saturation();
        int   n;
        logic got;
        do_reset();
        s_ch_en  = 4'b0001;
        sat_bit  = 1'b0;
        s_enable = 1'b1;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (s_valid) got = 1'b1;
            else sat_bit = ~sat_bit;
        end
        sat_bit = 1'b0;
        checks++; if (!got) begin errors++; $display("[TB] FAIL sat_timeout: got no valid, expected valid"); end
        checks++; if (s_res_cnt !== 3'd7) begin errors++; $display("[TB] FAIL sat_cnt: got %0d, expected 7", s_res_cnt); end
        checks++; if (s_res_ovf !== 1'b1) begin errors++; $display("[TB] FAIL sat_ovf: got %0d, expected 1", s_res_ovf); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("[TB] FAIL sat_busy: got %0d, expected 1", s_busy); end
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (s_valid) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("[TB] FAIL quiet_timeout: got no valid, expected valid"); end
        checks++; if (s_res_cnt !== 3'd0) begin errors++; $display("[TB] FAIL quiet_cnt: got %0d, expected 0", s_res_cnt); end
        checks++; if (s_res_ovf !== 1'b0) begin errors++; $display("[TB] FAIL quiet_ovf: got %0d, expected 0", s_res_ovf); end
        checks++; if (s_res_ch !== 2'd0) begin errors++; $display("[TB] FAIL quiet_ch: got %0d, expected 0", s_res_ch); end
        s_enable = 1'b0;
    endtask

    // Disabled channels are skipped; a single enabled channel repeats.
    task automatic test_mask();
        logic ok;
        int   waited;
        int   exp_ch [7] = '{1, 3, 1, 3, 2, 2, 2};
        do_reset();
        ch_en  = 4'b1010;
        enable = 1'b1;
        for (int r = 0; r < 7; r++) begin
            wait_valid(40, ok, waited);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL mask_timeout[%0d]: got no valid, expected valid within 40 cycles", r);
                break;
            end
            checks++; if (int'(res_ch) != exp_ch[r]) begin errors++; $display("[TB] FAIL mask_ch[%0d]: got %0d, expected %0d", r, res_ch, exp_ch[r]); end
            if (r == 3) ch_en = 4'b0100;
        end
        enable = 1'b0;
    endtask

    // Result held stable with ready low; transfer on the first ready edge.
    task automatic test_backpressure();
        logic       ok;
        int         waited;
        int         bad;
        logic [1:0] cap_ch;
        logic [7:0] cap_cnt;
        logic       cap_ovf;
        do_reset();
        ch_en  = 4'b1111;
        ready  = 1'b0;
        enable = 1'b1;
        wait_valid(40, ok, waited);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: got no valid, expected valid"); end
        checks++; if (res_ch !== 2'd0 || res_cnt !== 8'd8) begin errors++; $display("[TB] FAIL bp_first: got ch %0d cnt %0d, expected ch 0 cnt 8", res_ch, res_cnt); end
        cap_ch = res_ch; cap_cnt = res_cnt; cap_ovf = res_ovf;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_ch !== cap_ch || res_cnt !== cap_cnt ||
                res_ovf !== cap_ovf || cur_ch !== 2'd0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles, expected 0", bad); end
        ready = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_transfer: got valid %0d, expected 0", res_valid); end
        wait_valid(40, ok, waited);
        checks++; if (!ok || waited != 17) begin errors++; $display("[TB] FAIL bp_next_time: got %0d cycles, expected 17", waited); end
        checks++; if (res_ch !== 2'd1 || res_cnt !== 8'd4) begin errors++; $display("[TB] FAIL bp_next: got ch %0d cnt %0d, expected ch 1 cnt 4", res_ch, res_cnt); end
        enable = 1'b0;
    endtask

    // Abort in gate cycle 8 of channel 1; restart measures channel 1 again.
    task automatic test_abort();
        logic ok;
        int   waited;
        int   stray;
        do_reset();
        ch_en  = 4'b1111;
        enable = 1'b1;
        wait_valid(40, ok, waited);
        checks++; if (!ok || res_ch !== 2'd0) begin errors++; $display("[TB] FAIL abort_first: got ch %0d, expected 0", res_ch); end
        repeat (10) @(negedge clk);
        checks++; if (cur_ch !== 2'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_gate: got ch %0d busy %0d, expected 1 1", cur_ch, busy); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy %0d valid %0d, expected 0 0", busy, res_valid); end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", stray); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (cur_ch !== 2'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload: got ch %0d busy %0d, expected 1 1", cur_ch, busy); end
        wait_valid(40, ok, waited);
        checks++; if (!ok || waited != 17) begin errors++; $display("[TB] FAIL abort_retime: got %0d cycles, expected 17", waited); end
        checks++; if (res_ch !== 2'd1 || res_cnt !== 8'd4) begin errors++; $display("[TB] FAIL abort_result: got ch %0d cnt %0d, expected ch 1 cnt 4", res_ch, res_cnt); end
        enable = 1'b0;
    endtask

    // Asynchronous reset in the middle of a gate window.
    task automatic test_async_reset();
        logic ok;
        int   waited;
        do_reset();
        ch_en  = 4'b1111;
        enable = 1'b1;
        wait_valid(40, ok, waited);
        checks++; if (!ok || res_cnt !== 8'd8) begin errors++; $display("[TB] FAIL ar_first: got cnt %0d, expected 8", res_cnt); end
        repeat (8) @(negedge clk);
        checks++; if (cur_ch !== 2'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre: got ch %0d busy %0d, expected 1 1", cur_ch, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || cur_ch !== 2'd0) begin errors++; $display("[TB] FAIL ar_state: got busy %0d ch %0d, expected 0 0", busy, cur_ch); end
        checks++; if (res_valid !== 1'b0 || res_ch !== 2'd0) begin errors++; $display("[TB] FAIL ar_valid: got valid %0d ch %0d, expected 0 0", res_valid, res_ch); end
        checks++; if (res_cnt !== 8'd0 || res_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ar_result: got cnt %0d ovf %0d, expected 0 0", res_cnt, res_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(40, ok, waited);
        checks++; if (!ok || waited != 18) begin errors++; $display("[TB] FAIL ar_time: got %0d cycles, expected 18", waited); end
        checks++; if (res_ch !== 2'd0 || res_cnt !== 8'd8) begin errors++; $display("[TB] FAIL ar_after: got ch %0d cnt %0d, expected ch 0 cnt 8", res_ch, res_cnt); end
        enable = 1'b0;
    endtask

    // Test sequence.
    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        ch_en    = 4'b0000;
        ready    = 1'b1;
        s_enable = 1'b0;
        s_ch_en  = 4'b0001;
        s_ready  = 1'b1;
        sat_bit  = 1'b0;
        test_reset();
        test_round_robin();
        test_saturation();
        test_mask();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
